instruction_loader: RTL

Boot-time writer for the processor's byte-organised instruction memory. Accepts a framed byte stream on a valid/ready interface: 16-bit big-endian length header, payload bytes, XOR checksum. Writes each payload byte to consecutive instruction-memory byte addresses from 0, so memory reads it back big-endian four bytes per word. Holds the processor core in reset until a frame completes with a good checksum.

---
 rtl/instruction_loader_pkg.sv | 18 +
 rtl/instruction_loader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared processor definitions: instruction memory geometry and the
// boot-loader state encoding.
package instruction_loader_pkg;

    localparam int unsigned IMEM_DEPTH  = 512;
    localparam int unsigned IMEM_ADDR_W = 9;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } ld_state_e;

endpackage

// File: rtl/instruction_loader.sv
// Boot-time instruction memory writer: takes a framed byte stream
// (16-bit big-endian length, payload, XOR checksum), writes the payload to
// byte addresses 0.. and releases the core once the checksum matches.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    ld_state_e         state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       count_q, count_d;
    logic [7:0]        csum_q, csum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              xfer;

    // Level outputs decoded directly from the registered state.
    always_comb begin
        in_ready  = 1'b0;
        cpu_rst   = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        unique case (state_q)
            LD_LEN_HI, LD_LEN_LO, LD_DATA, LD_CSUM: in_ready = 1'b1;
            LD_DONE: begin
                cpu_rst   = 1'b0;
                load_done = 1'b1;
            end
            LD_ERR:  load_err = 1'b1;
            default: ;
        endcase
    end

    assign xfer = in_valid && in_ready;

    // Next-state, frame bookkeeping and the registered memory write request.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start) begin
                    state_d = LD_LEN_HI;
                    len_d   = '0;
                    count_d = '0;
                    csum_d  = '0;
                end
            end
            LD_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    state_d     = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    if ({len_q[15:8], in_data} > 16'(DEPTH)) begin
                        state_d = LD_ERR;
                    end else if ({len_q[15:8], in_data} == 16'd0) begin
                        state_d = LD_CSUM;
                    end else begin
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = count_q[ADDR_W-1:0];
                    mem_wdata_d = in_data;
                    csum_d      = csum_q ^ in_data;
                    count_d     = count_q + 16'd1;
                    if (count_q == len_q - 16'd1) begin
                        state_d = LD_CSUM;
                    end
                end
            end
            LD_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? LD_DONE : LD_ERR;
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    // State and datapath registers; reset cancels any pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LD_IDLE;
            len_q       <= '0;
            count_q     <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
